// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite codes, response-FSM states and byte-lane helpers for the
// AHB-to-SRAM bridge.
package ahb_sram_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      RESP_OKAY,
      RESP_ERR1,
      RESP_ERR2
   } resp_state_t;

   // Low address bits below the access size are ignored (aligned down).
   function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
      logic [3:0] m;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << addr;
         HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
         default:    m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr);
      logic e;
      case (size)
         HSIZE_BYTE: e = 1'b0;
         HSIZE_HALF: e = addr[0];
         HSIZE_WORD: e = (addr != 2'b00);
         default:    e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer: holds a write displaced by a read, and merges its
// bytes into read data returned for the same word.
module ahb_sram_wbuf
   import ahb_sram_pkg::*;
#(
   parameter int unsigned AW = 16
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          fill,
   input  logic          drain,
   input  logic [AW-1:0] fill_addr,
   input  logic [3:0]    fill_mask,
   input  logic [31:0]   fill_data,
   input  logic [AW-1:0] rd_addr,
   input  logic [31:0]   sram_rdata,
   output logic          buf_valid,
   output logic [AW-1:0] buf_addr,
   output logic [3:0]    buf_mask,
   output logic [31:0]   buf_data,
   output logic [31:0]   rd_merged
);

   logic hit;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         buf_valid <= 1'b0;
      end else if (fill) begin
         buf_valid <= 1'b1;
         buf_addr  <= fill_addr;
         buf_mask  <= fill_mask;
         buf_data  <= fill_data;
      end else if (drain) begin
         buf_valid <= 1'b0;
      end
   end

   assign hit = buf_valid && (buf_addr == rd_addr);

   always_comb begin
      rd_merged = sram_rdata;
      for (int unsigned i = 0; i < 4; i++) begin
         if (hit && buf_mask[i]) rd_merged[8*i +: 8] = buf_data[8*i +: 8];
      end
   end

endmodule

// File: rtl/ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite slave driving a single-port SRAM with a one-entry
// write buffer. Define AHB_SRAM_ALIGN_CHECK_EN to return ERROR on misaligned transfers.
module ahb_sram_bridge
   import ahb_sram_pkg::*;
#(
   parameter int unsigned AW = 16
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL,
   input  logic          HREADY,
   input  logic [1:0]    HTRANS,
   input  logic [2:0]    HSIZE,
   input  logic          HWRITE,
   input  logic [AW+1:0] HADDR,
   input  logic [31:0]   HWDATA,
   output logic          HREADYOUT,
   output logic          HRESP,
   output logic [31:0]   HRDATA,
   input  logic [31:0]   SRAMRDATA,
   output logic [AW-1:0] SRAMADDR,
   output logic [31:0]   SRAMWDATA,
   output logic [3:0]    SRAMWEN,
   output logic          SRAMCS
);

   logic          addr_valid, addr_err, rd_req, wr_req;
   logic [3:0]    addr_mask;
   logic          rd_dphase, wr_dphase;
   logic [AW-1:0] rd_addr, waddr;
   logic [3:0]    wmask;
   logic          buf_fill, buf_drain, buf_valid;
   logic [AW-1:0] buf_addr;
   logic [3:0]    buf_mask;
   logic [31:0]   buf_data, rd_merged;

   assign addr_valid = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
   assign addr_mask  = byte_mask(HSIZE, HADDR[1:0]);

`ifdef AHB_SRAM_ALIGN_CHECK_EN
   resp_state_t state;
   logic        hready_q, hresp_q;

   assign addr_err = addr_valid && misaligned(HSIZE, HADDR[1:0]);

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state    <= RESP_OKAY;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
      end else begin
         case (state)
            RESP_ERR1: begin
               state    <= RESP_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_ERROR;
            end
            default: begin
               if (addr_err) begin
                  state    <= RESP_ERR1;
                  hready_q <= 1'b0;
                  hresp_q  <= HRESP_ERROR;
               end else begin
                  state    <= RESP_OKAY;
                  hready_q <= 1'b1;
                  hresp_q  <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   assign HREADYOUT = hready_q;
   assign HRESP     = hresp_q;
`else
   assign addr_err  = 1'b0;
   assign HREADYOUT = 1'b1;
   assign HRESP     = HRESP_OKAY;
`endif

   assign rd_req = addr_valid && !HWRITE && !addr_err;
   assign wr_req = addr_valid &&  HWRITE && !addr_err;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         rd_dphase <= 1'b0;
         wr_dphase <= 1'b0;
      end else begin
         rd_dphase <= rd_req;
         wr_dphase <= wr_req;
         if (rd_req) rd_addr <= HADDR[AW+1:2];
         if (wr_req) begin
            waddr <= HADDR[AW+1:2];
            wmask <= addr_mask;
         end
      end
   end

   // Read address phase owns the port; a coinciding write data phase is parked.
   always_comb begin
      buf_fill  = 1'b0;
      buf_drain = 1'b0;
      SRAMCS    = 1'b0;
      SRAMWEN   = '0;
      SRAMADDR  = HADDR[AW+1:2];
      SRAMWDATA = HWDATA;
      if (HRESETn) begin
         if (rd_req) begin
            SRAMCS   = 1'b1;
            buf_fill = wr_dphase;
         end else if (wr_dphase) begin
            SRAMCS   = 1'b1;
            SRAMWEN  = wmask;
            SRAMADDR = waddr;
         end else if (buf_valid) begin
            SRAMCS    = 1'b1;
            SRAMWEN   = buf_mask;
            SRAMADDR  = buf_addr;
            SRAMWDATA = buf_data;
            buf_drain = 1'b1;
         end
      end
   end

   ahb_sram_wbuf #(.AW(AW)) u_wbuf (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .fill       (buf_fill),
      .drain      (buf_drain),
      .fill_addr  (waddr),
      .fill_mask  (wmask),
      .fill_data  (HWDATA),
      .rd_addr    (rd_addr),
      .sram_rdata (SRAMRDATA),
      .buf_valid  (buf_valid),
      .buf_addr   (buf_addr),
      .buf_mask   (buf_mask),
      .buf_data   (buf_data),
      .rd_merged  (rd_merged)
   );

   assign HRDATA = rd_dphase ? rd_merged : '0;

endmodule

// File: doc/ahb_sram_bridge.md
Name: ahb_sram_bridge

Overview:
- AHB-Lite slave that drives the on-chip SRAM port (ADDR/WDATA/WREN/CS in, registered one-cycle RDATA out); this block is the initiator side of that port.
- Zero-wait-state reads and writes; writes held in a one-entry write buffer and retired on the next cycle in which the SRAM port is not needed for a read.
- Read data is merged with pending buffered bytes so read-after-write is coherent.
- Sits between the AHB interconnect and each SRAM instance (code and data).

Parameters:
- AW, 16, SRAM word-address width; the AHB byte address is AW+2 bits.

Ports:
- HCLK  in  1  system clock; single clock domain.
- HRESETn  in  1  synchronous active-low reset, sampled on rising HCLK.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready; address phase sampled only when high.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HWRITE  in  1  1=write.
- HADDR  in  AW+2  byte address.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- SRAMRDATA  in  32  SRAM read data, valid one cycle after SRAMCS with SRAMWEN=0.
- SRAMADDR  out  AW  SRAM word address.
- SRAMWDATA  out  32  SRAM write data.
- SRAMWEN  out  4  per-byte write enable.
- SRAMCS  out  1  SRAM chip select.

Behaviour:
- Valid transfer: HSEL & HREADY & HTRANS[1].
- Byte mask:
  - byte: one-hot on HADDR[1:0]
  - half: 4'b0011 if HADDR[1]=0, else 4'b1100
  - word: 4'b1111
- Reset (HRESETn=0 at a clock edge):
  - HREADYOUT=1, HRESP=0.
  - buf_valid, rd_dphase and wr_dphase all cleared.
  - Any pending buffered write is discarded.
- While HRESETn=0, SRAMCS=0 and SRAMWEN=0 are forced combinationally.
- SRAM port priority each cycle:
  - Read address phase: SRAMCS=1, SRAMWEN=0, SRAMADDR=HADDR[AW+1:2].
  - Else write data phase: SRAMCS=1, SRAMWEN=wmask, SRAMADDR=waddr, SRAMWDATA=HWDATA (direct write).
  - Else buf_valid: write buffer to SRAM; clear buf_valid.
  - Else SRAMCS=0, SRAMWEN=0.
- Write data phase coinciding with a read address phase: latch {waddr, wmask, HWDATA} into the buffer and set buf_valid.
- Invariant: a write data phase always follows a write address phase, which is a non-read cycle, so the buffer is empty before a refill. Depth 1 is sufficient and no stalls are ever needed.
- Read data phase: HRDATA bytes come from the buffer where buf_valid & (buf_addr==rd_addr) & buf_mask[i]; all other bytes come from SRAMRDATA.
- HRDATA=0 outside a read data phase.
- Latency: OKAY responses always have HREADYOUT=1; read data is returned in the data phase immediately after the address phase.
- Response FSM states: OKAY, ERR1, ERR2 (ERR states exist only with the optional feature).
- IDLE/BUSY transfers and HSEL=0 get an OKAY response with no SRAM access.

Optional Feature:
- AHB_SRAM_ALIGN_CHECK_EN defined:
  - Error conditions: halfword with HADDR[0]=1, word with HADDR[1:0]!=0, or HSIZE>2.
  - Response: OKAY -> ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1) -> OKAY.
  - No SRAM access and no buffer update occur for the faulting transfer.
- Undefined: low address bits below the size are ignored (access is aligned down); HRESP is tied to 0 and the FSM collapses to OKAY.

Decomposition:
- Package ahb_sram_pkg holds:
  - HTRANS codes (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - HSIZE codes
  - HRESP_OKAY/HRESP_ERROR
  - response FSM state encoding
  - byte-mask function
- Sub-module ahb_sram_wbuf: buffer registers, buf_valid, address compare, byte merge.

Test Plan:
- Word write 0xDEADBEEF to 0x0010, then idle -> SRAMWEN=4'hF, SRAMADDR=4, SRAMWDATA=0xDEADBEEF in the write data phase; a later read returns 0xDEADBEEF.
- Byte write 0xAA to 0x0013 immediately followed by a read of 0x0010 (old word 0x11223344) -> write is buffered; HRDATA=0xAA223344 with zero wait; buffer drains on the next non-read cycle.
- Back-to-back W,R,W,R to distinct addresses -> HREADYOUT stays 1 throughout; the SRAM ends with both writes applied; reads return correct pre-write data.
- Halfword write 0xBEEF to 0x0022 -> SRAMWEN=4'b1100, SRAMWDATA[31:16]=0xBEEF.
- With AHB_SRAM_ALIGN_CHECK_EN, word read at 0x0002 -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1, SRAMCS=0 throughout. Without the macro -> OKAY; reads word 0.
- HRESETn low one cycle while buf_valid=1 -> buffer discarded, SRAMWEN=0, HREADYOUT=1, HRESP=0 afterwards.
